decoder_scan: RTL and testbench

Parametrised SEL_W-to-2^SEL_W binary decoder with registered, active-low one-cold outputs and an active-low enable. It is the successor of the combinational 2:4 decoder. A built-in scan mode automatically steps the active output through every index with a programmable dwell time. It drives multiplexed LED/keypad row selects and chip-selects where either direct decoding or free-running scanning is needed.

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_scan_timer.sv | 33 +++
 rtl/decoder_scan.sv | 82 ++++++++
 tb/tb_decoder_scan.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-cold decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  // Active-low one-hot of idx; callers truncate to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onecold(input logic [MAX_SEL_W-1:0] idx,
                                                   input int width);
    logic [MAX_OUT_W-1:0] v;
    v = '1;
    if (int'(idx) < width) v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// Dwell register plus down-counter; step fires on the cycle the count expires.
module scan_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_reload;

  // A load coinciding with a reload takes effect immediately.
  assign w_reload = load ? dwell : r_dwell;
  assign step     = run && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_cnt   <= '0;
    end else begin
      if (load) r_dwell <= dwell;
      if (start || step) r_cnt <= w_reload;
      else if (run)      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-cold decoder with direct-select and auto-scan modes.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 2,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  state_t             r_state, w_state_nxt;
  logic [OUT_W-1:0]   r_y, w_y_nxt;
  logic [SEL_W-1:0]   r_idx, w_idx_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic               w_start, w_run, w_step;

  scan_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .run   (w_run),
    .load  (load),
    .dwell (dwell),
    .step  (w_step)
  );

  always_comb begin
    w_state_nxt = IDLE;
    w_y_nxt     = '1;
    w_idx_nxt   = '0;
    w_wrap_nxt  = 1'b0;
    if (!en_n) w_state_nxt = mode ? SCAN : DIRECT;
    // Any entry into SCAN restarts from index 0; only steady scanning advances.
    w_start = (w_state_nxt == SCAN) && (r_state != SCAN);
    w_run   = (w_state_nxt == SCAN) && (r_state == SCAN);
    case (w_state_nxt)
      DIRECT: w_idx_nxt = sel;
      SCAN: begin
        if (w_run) begin
          if (w_step) begin
            w_idx_nxt  = r_idx + SEL_W'(1);
            w_wrap_nxt = &r_idx;
          end else begin
            w_idx_nxt = r_idx;
          end
        end
      end
      default: w_idx_nxt = '0;
    endcase
    if (w_state_nxt != IDLE)
      w_y_nxt = OUT_W'(onecold(MAX_SEL_W'(w_idx_nxt), OUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= '1;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Randomised bench for decoder_scan with a cycle-level behavioural model.
module tb_decoder_scan;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en_n = 1'b1;
  logic               mode = 1'b0;
  logic [SEL_W-1:0]   sel = 2'd3;
  logic               load = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en_n  (en_n),
    .mode  (mode),
    .sel   (sel),
    .load  (load),
    .dwell (dwell),
    .y     (y),
    .idx   (idx),
    .wrap  (wrap)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_on  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: m_mode 0 idle, 1 direct, 2 scan; current index shown m_age of m_len cycles.
  int m_mode = 0, m_idx = 0, m_wrap = 0, m_dwell = 0, m_age = 0, m_len = 1;

  function automatic int m_y();
    return (m_mode == 0) ? 15 : (15 & ~(1 << m_idx));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_idx <= 0; m_wrap <= 0; m_dwell <= 0; m_age <= 0; m_len <= 1;
    end else begin
      if (en_n) begin
        m_mode <= 0; m_idx <= 0; m_wrap <= 0;
      end else if (!mode) begin
        m_mode <= 1; m_idx <= int'(sel); m_wrap <= 0;
      end else if (m_mode != 2) begin
        m_mode <= 2; m_idx <= 0; m_wrap <= 0; m_age <= 1;
        m_len  <= (load ? int'(dwell) : m_dwell) + 1;
      end else if (m_age == m_len) begin
        m_idx  <= (m_idx + 1) % OUT_W;
        m_wrap <= (m_idx == OUT_W - 1) ? 1 : 0;
        m_age  <= 1;
        m_len  <= (load ? int'(dwell) : m_dwell) + 1;
      end else begin
        m_age <= m_age + 1; m_wrap <= 0;
      end
      if (load) m_dwell <= int'(dwell);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("y", int'(y), m_y());
      chk("idx", int'(idx), m_idx);
      chk("wrap", int'(wrap), m_wrap);
      chk("single_low", ($countones(~y) <= 1) ? 1 : 0, 1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dir_exp [4];
  int v;
  int n;

  initial begin
    dir_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    #2 rst_n = 1'b0;
    cmp_on = 1'b1;
    #1;
    chk("rst_y", int'(y), 15);
    chk("rst_idx", int'(idx), 0);
    chk("rst_wrap", int'(wrap), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_y", int'(y), 15);
    chk("idle_idx", int'(idx), 0);

    // Direct decode of each index.
    en_n = 1'b0; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cyc();
      chk("dir_y", int'(y), int'(dir_exp[s]));
      chk("dir_idx", int'(idx), s);
      chk("model_dir", m_y(), int'(dir_exp[s]));
    end

    // dwell=2 scan: 3 cycles per index, 12-cycle period, wrap on return to 0.
    en_n = 1'b1; load = 1'b1; dwell = 8'd2;
    cyc();
    load = 1'b0; mode = 1'b1; en_n = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("scan_y", int'(y), (i < 12) ? int'(dir_exp[i/3]) : 14);
      chk("scan_wrap", int'(wrap), (i == 12) ? 1 : 0);
    end
    chk("model_wrap", m_wrap, 1);

    // dwell=0 steps every cycle; load 4 on a step holds that index 5 cycles.
    load = 1'b1; dwell = 8'd0;
    cyc();
    load = 1'b0;
    repeat (8) cyc();
    v = int'(idx);
    cyc();
    chk("dwell0_step", int'(idx), (v + 1) % 4);
    load = 1'b1; dwell = 8'd4;
    cyc();
    load = 1'b0;
    v = int'(idx);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("hold5", int'(idx), v);
    end
    cyc();
    chk("hold5_step", int'(idx), (v + 1) % 4);

    // Leave scan at idx 2 for one cycle, then restart with full dwell.
    n = 0;
    while (idx != 2'd2 && n < 40) begin
      cyc();
      n++;
    end
    chk("reach_idx2", int'(idx), 2);
    en_n = 1'b1;
    cyc();
    chk("leave_y", int'(y), 15);
    chk("leave_idx", int'(idx), 0);
    en_n = 1'b0;
    cyc();
    chk("reenter_y", int'(y), 14);
    chk("reenter_wrap", int'(wrap), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("reenter_hold", int'(idx), 0);
    end
    cyc();
    chk("reenter_step", int'(idx), 1);

    // Drop to direct mid-scan and come back.
    mode = 1'b0; sel = 2'd3;
    cyc();
    chk("toggle_dir_y", int'(y), 7);
    mode = 1'b1;
    cyc();
    chk("toggle_scan_y", int'(y), 14);
    chk("toggle_scan_idx", int'(idx), 0);

    // Random traffic in blocks with a fixed mode per block.
    for (int b = 0; b < 60; b++) begin
      mode = 1'($urandom_range(0, 2) != 0);
      for (int c = 0; c < 50; c++) begin
        en_n  = ($urandom_range(0, 19) == 0);
        sel   = 2'($urandom);
        load  = ($urandom_range(0, 15) == 0);
        dwell = 8'($urandom_range(0, 5));
        cyc();
      end
    end

    // Async reset mid-scan clears outputs immediately and the dwell register.
    en_n = 1'b0; mode = 1'b1; load = 1'b1; dwell = 8'd3;
    cyc();
    load = 1'b0;
    repeat (6) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", int'(y), 15);
    chk("async_rst_idx", int'(idx), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_entry", int'(idx), 0);
    cyc();
    chk("post_rst_step", int'(idx), 1);
    repeat (10) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
